// File: rtl/keymap_decoder.sv
// PS/2 Set-2 scancode decoder for the two players' movement keys; publishes a frame-latched held vector.
// Optional build macro KEYMAP_ESC_CLEAR_EN: a plain Esc (76) make in Idle clears every held bit.
module keymap_decoder #(
    parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       ScanValid,
    input  logic [7:0] ScanCode,
    output logic       ScanReady,
    input  logic       FrameTick,
    output logic [7:0] Keycode,
    output logic [7:0] Held,
    output logic       ProtoErr
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_ESC = 8'h76;

    state_t      state;
    state_t      state_next;
    state_t      dec_state;
    logic [15:0] pfx_cnt;
    logic        accept;
    logic        timeout;
    logic [7:0]  base_mask;
    logic [7:0]  ext_mask;
    logic [7:0]  held_next;
    logic        proto_err_next;

    assign accept  = ScanValid && ScanReady;
    assign timeout = (state != IDLE) && (pfx_cnt == PREFIX_TIMEOUT);
    // An expiring prefix is abandoned first, so a byte arriving on that cycle starts fresh.
    assign dec_state = timeout ? IDLE : state;

    // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
    always_comb begin
        base_mask = 8'h00;
        case (ScanCode)
            8'h1C:   base_mask = 8'h80;
            8'h23:   base_mask = 8'h40;
            8'h1D:   base_mask = 8'h20;
            8'h1B:   base_mask = 8'h10;
            default: base_mask = 8'h00;
        endcase
    end

    always_comb begin
        ext_mask = 8'h00;
        case (ScanCode)
            8'h6B:   ext_mask = 8'h08;
            8'h74:   ext_mask = 8'h04;
            8'h75:   ext_mask = 8'h02;
            8'h72:   ext_mask = 8'h01;
            default: ext_mask = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = dec_state;
        if (accept) begin
            case (dec_state)
                IDLE: begin
                    if (ScanCode == CODE_EXT)      state_next = EXT;
                    else if (ScanCode == CODE_BRK) state_next = BRK;
                    else                           state_next = IDLE;
                end
                EXT:     state_next = (ScanCode == CODE_BRK) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        held_next      = Held;
        proto_err_next = timeout;
        if (accept) begin
            case (dec_state)
                IDLE: begin
                    held_next = Held | base_mask;
`ifdef KEYMAP_ESC_CLEAR_EN
                    if (ScanCode == CODE_ESC) held_next = 8'h00;
`endif
                end
                EXT: begin
                    if (ScanCode == CODE_EXT) proto_err_next = 1'b1;
                    else                      held_next = Held | ext_mask;
                end
                BRK: begin
                    if (ScanCode == CODE_EXT || ScanCode == CODE_BRK) proto_err_next = 1'b1;
                    else                                              held_next = Held & ~base_mask;
                end
                default: begin
                    if (ScanCode == CODE_EXT || ScanCode == CODE_BRK) proto_err_next = 1'b1;
                    else                                              held_next = Held & ~ext_mask;
                end
            endcase
        end
    end

`ifndef KEYMAP_ESC_CLEAR_EN
    // Esc is an ordinary unmapped code in this build.
    logic unused_esc;
    assign unused_esc = ^CODE_ESC;
`endif

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ScanReady <= 1'b0;
            Held      <= 8'h00;
            Keycode   <= 8'h00;
            ProtoErr  <= 1'b0;
            pfx_cnt   <= 16'd0;
        end else begin
            ScanReady <= 1'b1;
            Held      <= held_next;
            ProtoErr  <= proto_err_next;
            // Keycode takes the pre-update Held, so a byte on the tick cycle waits one frame.
            if (FrameTick) Keycode <= Held;
            if (accept || timeout)  pfx_cnt <= 16'd0;
            else if (state != IDLE) pfx_cnt <= pfx_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_keymap_decoder.sv
// Self-checking bench for keymap_decoder: directed scenarios plus random scancode streams
// checked against a byte-level reference model of the key tracker.
module tb_keymap_decoder;

    localparam logic [15:0] TMO = 16'd40;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       ScanValid = 1'b0;
    logic [7:0] ScanCode = 8'h00;
    logic       ScanReady;
    logic       FrameTick = 1'b0;
    logic [7:0] Keycode;
    logic [7:0] Held;
    logic       ProtoErr;

    keymap_decoder #(.PREFIX_TIMEOUT(TMO)) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .ScanValid (ScanValid),
        .ScanCode  (ScanCode),
        .ScanReady (ScanReady),
        .FrameTick (FrameTick),
        .Keycode   (Keycode),
        .Held      (Held),
        .ProtoErr  (ProtoErr)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: held keys, pending prefixes, last protocol-error flag, frame copy.
    logic [7:0] m_held;
    logic [7:0] m_key;
    bit         m_ext;
    bit         m_brk;
    bit         m_perr;

    logic [7:0] plain_codes [4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
    logic [7:0] ext_codes   [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] key_bit(input logic [7:0] c, input bit ext);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (!ext && c == plain_codes[i]) m = 8'h80 >> i;
            if (ext && c == ext_codes[i])    m = 8'h08 >> i;
        end
        return m;
    endfunction

    task automatic model_byte(input logic [7:0] c);
        bit pfx_code = (c == 8'hE0) || (c == 8'hF0);
        if (m_brk) begin
            if (pfx_code) m_perr = 1'b1;
            else          m_held = m_held & ~key_bit(c, m_ext);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (c == 8'hF0) m_brk = 1'b1;
            else begin
                if (c == 8'hE0) m_perr = 1'b1;
                else            m_held = m_held | key_bit(c, 1'b1);
                m_ext = 1'b0;
            end
        end else begin
            if (c == 8'hE0)      m_ext = 1'b1;
            else if (c == 8'hF0) m_brk = 1'b1;
            else                 m_held = m_held | key_bit(c, 1'b0);
`ifdef KEYMAP_ESC_CLEAR_EN
            if (c == 8'h76) m_held = 8'h00;
`endif
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [7:0] c, input bit t);
        ScanValid = v;
        ScanCode  = c;
        FrameTick = t;
        @(posedge Clk);
        m_perr = 1'b0;
        if (t) m_key = m_held;
        if (v) model_byte(c);
        @(negedge Clk);
        ScanValid = 1'b0;
        FrameTick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        ResetN = 1'b0;
        m_held = 8'h00; m_key = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0;
        @(negedge Clk);
        check("rst_ready", {7'd0, ScanReady}, 8'h00);
        ResetN = 1'b1;
        @(negedge Clk);
        check("ready_after_rst", {7'd0, ScanReady}, 8'h01);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_held"}, Held, m_held);
        check({tag, "_key"}, Keycode, m_key);
        check({tag, "_perr"}, {7'd0, ProtoErr}, {7'd0, m_perr});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int first_at;
        logic [7:0] pick [13] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75,
                                  8'h72, 8'hE0, 8'hF0, 8'h76, 8'h29, 8'h00};

        // Reset values
        do_reset();
        check("rst_held", Held, 8'h00);
        check("rst_key", Keycode, 8'h00);
        check("rst_perr", {7'd0, ProtoErr}, 8'h00);

        // W make / break with frame latching
        cycle(1, 8'h1D, 0);
        check("w_held", Held, 8'h20);
        check("w_key_pre_tick", Keycode, 8'h00);
        cycle(0, 8'h00, 1);
        check("w_key", Keycode, 8'h20);
        cycle(1, 8'hF0, 0);
        cycle(1, 8'h1D, 0);
        cycle(0, 8'h00, 1);
        check("w_brk_key", Keycode, 8'h00);

        // Extended makes and an extended break
        do_reset();
        cycle(1, 8'hE0, 0); cycle(1, 8'h75, 0);
        cycle(1, 8'hE0, 0); cycle(1, 8'h6B, 0);
        cycle(1, 8'h1C, 0); cycle(0, 8'h00, 1);
        check("ext_key", Keycode, 8'h8A);
        cycle(1, 8'hE0, 0); cycle(1, 8'hF0, 0); cycle(1, 8'h6B, 0);
        cycle(0, 8'h00, 1);
        check("ext_brk_key", Keycode, 8'h82);

        // Keypad codes without E0 and E0-prefixed letter codes touch nothing
        do_reset();
        cycle(1, 8'h75, 0); cycle(1, 8'hE0, 0); cycle(1, 8'h1C, 0);
        check("cross_map", Held, 8'h00);

        // Byte accepted on the tick cycle appears one frame later
        do_reset();
        cycle(1, 8'h1C, 1);
        check("same_tick_key", Keycode, 8'h00);
        check("same_tick_held", Held, 8'h80);
        cycle(0, 8'h00, 1);
        check("next_tick_key", Keycode, 8'h80);

        // Illegal F0 E0
        do_reset();
        cycle(1, 8'hF0, 0); cycle(1, 8'hE0, 0);
        check("f0e0_perr", {7'd0, ProtoErr}, 8'h01);
        cycle(1, 8'h1B, 0);
        check("f0e0_perr_once", {7'd0, ProtoErr}, 8'h00);
        check("f0e0_then_s", Held, 8'h10);

        // Prefix timeout: one pulse, then the stale E0 no longer applies
        do_reset();
        cycle(1, 8'hE0, 0);
        pulses = 0;
        first_at = -1;
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            cycle(0, 8'h00, 0);
            if (ProtoErr) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("tmo_pulses", 8'(pulses), 8'd1);
        check("tmo_in_window", {7'd0, (first_at >= int'(TMO) && first_at <= int'(TMO) + 2)}, 8'h01);
        cycle(1, 8'h75, 0);
        check("tmo_held", Held, 8'h00);

        // Esc clear (build dependent)
        do_reset();
        cycle(1, 8'h1C, 0); cycle(1, 8'hE0, 0); cycle(1, 8'h72, 0); cycle(1, 8'h76, 0);
`ifdef KEYMAP_ESC_CLEAR_EN
        check("esc_held", Held, 8'h00);
`else
        check("esc_held", Held, 8'h81);
`endif
        cycle(1, 8'hF0, 0); cycle(1, 8'h76, 0);
        check("esc_brk_held", Held, m_held);

        // Asynchronous reset mid-sequence
        do_reset();
        cycle(1, 8'h23, 0); cycle(1, 8'hE0, 0); cycle(0, 8'h00, 1);
        #3;
        ResetN = 1'b0;
        #1;
        check("async_held", Held, 8'h00);
        check("async_key", Keycode, 8'h00);
        check("async_ready", {7'd0, ScanReady}, 8'h00);
        @(negedge Clk);
        ResetN = 1'b1;
        m_held = 8'h00; m_key = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0;
        @(negedge Clk);
        cycle(1, 8'h75, 0);
        check("async_idle", Held, 8'h00);

        // Random streams against the model; gaps stay far below the timeout
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cycle(0, 8'h00, ($urandom_range(0, 7) == 0));
            cycle(1, pick[$urandom_range(0, 12)], ($urandom_range(0, 5) == 0));
            check_model("rnd");
        end
        cycle(0, 8'h00, 1);
        check_model("rnd_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keymap_decoder.md
# keymap_decoder

Converts the stream of PS/2 Set-2 scancode bytes from the keyboard receiver into the 8-bit held-key vector `Keycode` that both player instances consume. It tracks make and break codes, including `E0`-extended codes, for the two players' movement keys. It publishes a frame-stable copy of the vector once per `FrameTick`, so a player never sees the vector change mid-frame. It sits between the PS/2 byte receiver and the two `player` blocks in the top level.

## Interface
- Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `PREFIX_TIMEOUT`, default 16'd50000: cycles a prefix state (`E0`/`F0`) may wait for its next byte before abandoning the sequence.

Ports:
- `Clk`  in  1  system clock (50 MHz)
- `ResetN`  in  1  asynchronous active-low reset
- `ScanValid`  in  1  scancode byte present on `ScanCode`
- `ScanCode`  in  8  scancode byte from the PS/2 receiver
- `ScanReady`  out  1  decoder accepts a byte this cycle
- `FrameTick`  in  1  single-cycle pulse at frame start (synchronous to `Clk`)
- `Keycode`  out  8  frame-latched held vector, driven to both players
- `Held`  out  8  live held vector, updated on every accepted byte
- `ProtoErr`  out  1  one-cycle pulse on an illegal prefix sequence or a prefix timeout

## Operation
- A byte is accepted on any cycle where `ScanValid && ScanReady`.
- `ScanReady` is registered. It is 0 in reset and 1 from the first `Clk` edge after `ResetN` rises. It stays 1 thereafter, so there is no back-pressure.
- Bit map:
  - `[7]` A `1C` (P1 left), `[6]` D `23` (P1 right), `[5]` W `1D` (P1 up), `[4]` S `1B` (P1 down).
  - `[3]` `E0 6B` (P2 left), `[2]` `E0 74` (P2 right), `[1]` `E0 75` (P2 up), `[0]` `E0 72` (P2 down).
- FSM states: `Idle`, `Ext`, `Brk`, `ExtBrk`.
  - `Idle`:
    - `E0` goes to `Ext`.
    - `F0` goes to `Brk`.
    - A mapped non-extended code sets its bit; stay in `Idle`.
    - Any other byte is ignored.
  - `Ext`:
    - `F0` goes to `ExtBrk`.
    - A mapped extended code sets its bit, then goes to `Idle`.
    - `E0` pulses `ProtoErr`, then goes to `Idle`.
    - Any other byte goes to `Idle` silently.
  - `Brk`:
    - A mapped non-extended code clears its bit, then goes to `Idle`.
    - `E0` or `F0` pulses `ProtoErr`, then goes to `Idle`.
    - Any other byte goes to `Idle`.
  - `ExtBrk`:
    - A mapped extended code clears its bit, then goes to `Idle`.
    - `E0` or `F0` pulses `ProtoErr`, then goes to `Idle`.
    - Any other byte goes to `Idle`.
- Non-extended `75`, `6B`, `74` and `72` (keypad codes) never touch bits `[3:0]`. Extended `1C`, `23`, `1D` and `1B` never touch bits `[7:4]`.
- Opposing keys may be held simultaneously. Both bits are reported; the player resolves the conflict with XOR.
- Repeated make codes (typematic repeat) re-set an already-set bit, with no other effect.

## Timing
- Reset values: `Keycode` = 8'h00, `Held` = 8'h00, `ScanReady` = 0, `ProtoErr` = 0, state `Idle`, timeout counter 0.
- `Held` updates on the edge that accepts the byte and is visible the next cycle (1-cycle latency).
- `Keycode` loads `Held` on the edge where `FrameTick` = 1.
- If a byte is accepted in the same cycle as `FrameTick`, `Keycode` captures the pre-update `Held`. The new bit appears at the following `FrameTick`.
- Prefix timeout:
  - A 16-bit counter clears on every accepted byte and increments each cycle while the state is not `Idle`.
  - When it reaches `PREFIX_TIMEOUT`, the FSM returns to `Idle` and `ProtoErr` pulses for 1 cycle.
  - A byte accepted in that same cycle is decoded in the `Idle` context.
- `ProtoErr` is registered and is high for exactly 1 cycle per event.
- Reset asserted mid-sequence immediately returns every register to its reset value, regardless of `Clk`.

## Configuration
- `KEYMAP_ESC_CLEAR_EN`:
  - Defined: a non-extended `76` (Esc) make code accepted in `Idle` clears `Held` to 8'h00 on that edge. This recovers from lost break codes.
  - Not defined: `76` is an ordinary unmapped code and is ignored.
  - The `F0 76` break is ignored in both builds.

## Test plan
- Reset, then `1D`, then `FrameTick` → `Held` = 8'h20 one cycle after acceptance, `Keycode` = 8'h20 after the tick; then `F0 1D` plus tick → `Keycode` = 8'h00.
- `E0 75`, `E0 6B`, `1C`, tick → `Keycode` = 8'h8A; then `E0 F0 6B` plus tick → 8'h82.
- `1C` accepted in the same cycle as `FrameTick` → `Keycode` stays 8'h00 at that tick, becomes 8'h80 at the next tick.
- `F0 E0` → `ProtoErr` pulses once and the FSM is in `Idle`; the following `1B` sets bit 4 (`Held` = 8'h10).
- `E0`, idle for `PREFIX_TIMEOUT` cycles, then `75` → `ProtoErr` pulse at timeout, `Held` unchanged (8'h00).
- With `KEYMAP_ESC_CLEAR_EN`: `1C`, `E0 72`, `76` → `Held` = 8'h00. Without the macro, the same sequence → `Held` = 8'h81.
